// File: rtl/descriptor_streamer_if.sv
// Byte stream handshake between the descriptor streamer and the UART side.
// master drives data/valid, slave returns ready.
interface descriptor_streamer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/descriptor_streamer.sv
// Drains the descriptor BRAM as a framed MSB-first byte stream.
// Optional trailing XOR checksum byte: define DESCRIPTOR_STREAMER_CHECKSUM_EN.
module descriptor_streamer #(
    parameter int          DIMENSION  = 64,
    parameter int          PATCH_SIZE = 4,
    parameter logic [7:0]  HEADER     = 8'hA5,
    localparam int ADDR_W = $clog2(DIMENSION * DIMENSION),
    localparam int DESC_W =
        ($clog2(PATCH_SIZE / 2 * PATCH_SIZE / 2) + 1) * 8,
    localparam int NBYTES = DESC_W / 8
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              start,
    input  logic [ADDR_W-1:0] desc_count,
    output logic [ADDR_W-1:0] desc_read_addr,
    input  logic [DESC_W-1:0] desc_read,
    descriptor_streamer_if.master byte_if,
    output logic              busy,
    output logic              stream_done
);

    // bidx indexes both the 3 header bytes and the NBYTES data bytes
    localparam int BW = ($clog2(NBYTES) > 2) ? $clog2(NBYTES) : 2;
    localparam logic [BW-1:0] LAST_B = BW'(NBYTES - 1);
    localparam logic [BW-1:0] LAST_H = BW'(2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_FETCH,
        ST_SEND,
`ifdef DESCRIPTOR_STREAMER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W:0]   widx;
    logic [ADDR_W:0]   widx_nx;
    logic [BW-1:0]     bidx;
    logic [1:0]        fcnt;
    logic [DESC_W-1:0] shreg;
    logic [15:0]       cnt16;
`ifdef DESCRIPTOR_STREAMER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign cnt16   = 16'(cnt);
    assign widx_nx = widx + (ADDR_W + 1)'(1);

    function automatic logic [7:0] hdr_sel(input logic [BW-1:0] i);
        case (i)
            BW'(0):  hdr_sel = HEADER;
            BW'(1):  hdr_sel = cnt16[15:8];
            default: hdr_sel = cnt16[7:0];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            widx               <= '0;
            bidx               <= '0;
            fcnt               <= '0;
            shreg              <= '0;
            desc_read_addr     <= '0;
            byte_if.byte_data  <= '0;
            byte_if.byte_valid <= 1'b0;
            busy               <= 1'b0;
            stream_done        <= 1'b0;
`ifdef DESCRIPTOR_STREAMER_CHECKSUM_EN
            csum               <= '0;
`endif
        end else begin
            stream_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt   <= desc_count;
                        widx  <= '0;
                        bidx  <= '0;
                        busy  <= 1'b1;
                        state <= ST_HEADER;
`ifdef DESCRIPTOR_STREAMER_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                ST_HEADER: begin
                    if (!byte_if.byte_valid) begin
                        byte_if.byte_valid <= 1'b1;
                        byte_if.byte_data  <= hdr_sel(bidx);
                    end else if (byte_if.byte_ready) begin
`ifdef DESCRIPTOR_STREAMER_CHECKSUM_EN
                        csum <= csum ^ byte_if.byte_data;
`endif
                        if (bidx == LAST_H) begin
                            byte_if.byte_valid <= 1'b0;
                            bidx <= '0;
                            if (cnt != '0) begin
                                state          <= ST_FETCH;
                                fcnt           <= '0;
                                desc_read_addr <= widx[ADDR_W-1:0];
                            end else begin
`ifdef DESCRIPTOR_STREAMER_CHECKSUM_EN
                                state <= ST_CHECK;
`else
                                state       <= ST_DONE;
                                stream_done <= 1'b1;
                                busy        <= 1'b0;
`endif
                            end
                        end else begin
                            bidx <= bidx + BW'(1);
                            byte_if.byte_data <= hdr_sel(bidx + BW'(1));
                        end
                    end
                end
                ST_FETCH: begin
                    // address, wait, capture: matches the 2-cycle BRAM read
                    if (fcnt == 2'd2) begin
                        shreg <= desc_read;
                        bidx  <= '0;
                        state <= ST_SEND;
                    end else begin
                        fcnt <= fcnt + 2'd1;
                    end
                end
                ST_SEND: begin
                    if (!byte_if.byte_valid) begin
                        byte_if.byte_valid <= 1'b1;
                        byte_if.byte_data  <= shreg[DESC_W-1 -: 8];
                        shreg <= shreg << 8;
                    end else if (byte_if.byte_ready) begin
`ifdef DESCRIPTOR_STREAMER_CHECKSUM_EN
                        csum <= csum ^ byte_if.byte_data;
`endif
                        if (bidx == LAST_B) begin
                            byte_if.byte_valid <= 1'b0;
                            bidx <= '0;
                            widx <= widx_nx;
                            if (widx_nx == {1'b0, cnt}) begin
`ifdef DESCRIPTOR_STREAMER_CHECKSUM_EN
                                state <= ST_CHECK;
`else
                                state       <= ST_DONE;
                                stream_done <= 1'b1;
                                busy        <= 1'b0;
`endif
                            end else begin
                                state          <= ST_FETCH;
                                fcnt           <= '0;
                                desc_read_addr <= widx_nx[ADDR_W-1:0];
                            end
                        end else begin
                            bidx <= bidx + BW'(1);
                            byte_if.byte_data <= shreg[DESC_W-1 -: 8];
                            shreg <= shreg << 8;
                        end
                    end
                end
`ifdef DESCRIPTOR_STREAMER_CHECKSUM_EN
                ST_CHECK: begin
                    if (!byte_if.byte_valid) begin
                        byte_if.byte_valid <= 1'b1;
                        byte_if.byte_data  <= csum;
                    end else if (byte_if.byte_ready) begin
                        byte_if.byte_valid <= 1'b0;
                        state       <= ST_DONE;
                        stream_done <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
